// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader feeding a word-addressed instruction RAM.
// The core is held in reset until the whole image has been loaded.
module imem_boot_loader #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
  output logic        core_rst_n,
  output logic        load_done,
  output logic        load_err,
  input  logic [31:0] pcF,
  output logic [31:0] instrF
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  typedef enum logic [2:0] {StLenLo, StLenHi, StData, StRun, StErr} state_e;

  state_e                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [DEPTH_LOG2:0]   addr_q, addr_d;
  logic [1:0]            bidx_q, bidx_d;
  logic [23:0]           part_q, part_d;
  logic [Depth-1:0]      wvalid_q;
  logic                  core_rst_q;
  logic [31:0]           mem [Depth];

  logic                  accept;
  logic                  we;
  logic [31:0]           wdata;
  logic [15:0]           len_full;
  logic [DEPTH_LOG2-1:0] waddr;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  unused_pc;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    addr_d   = addr_q;
    bidx_d   = bidx_q;
    part_d   = part_q;
    we       = 1'b0;
    ld_ready = (state_q == StLenLo) || (state_q == StLenHi) || (state_q == StData);
    accept   = ld_valid && ld_ready;
    len_full = {ld_data, len_q[7:0]};
    wdata    = {ld_data, part_q};

    unique case (state_q)
      StLenLo: begin
        if (accept) begin
          len_d[7:0] = ld_data;
          state_d    = StLenHi;
        end
      end
      StLenHi: begin
        if (accept) begin
          len_d = len_full;
          if (len_full == 16'd0) begin
            state_d = StRun;
          end else if (32'(len_full) > Depth) begin
            state_d = StErr;
          end else begin
            state_d = StData;
            addr_d  = '0;
            bidx_d  = '0;
          end
        end
      end
      StData: begin
        if (accept) begin
          bidx_d = bidx_q + 2'd1;
          // Bytes shift in from the top so the first one ends up in bits [7:0].
          part_d = {ld_data, part_q[23:8]};
          if (bidx_q == 2'd3) begin
            we     = 1'b1;
            addr_d = addr_q + 1'b1;
            if (16'(addr_q) == len_q - 16'd1) begin
              state_d = StRun;
            end
          end
        end
      end
      StRun, StErr: ;
      default: state_d = StLenLo;
    endcase
  end

  assign waddr = addr_q[DEPTH_LOG2-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StLenLo;
      len_q      <= '0;
      addr_q     <= '0;
      bidx_q     <= '0;
      part_q     <= '0;
      wvalid_q   <= '0;
      core_rst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      bidx_q     <= bidx_d;
      part_q     <= part_d;
      core_rst_q <= (state_q == StRun);
      if (we) begin
        wvalid_q[waddr] <= 1'b1;
      end
    end
  end

  // RAM contents survive reset; wvalid alone decides what reads back.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rd_idx     = pcF[DEPTH_LOG2+1:2];
  assign instrF     = wvalid_q[rd_idx] ? mem[rd_idx] : NOP_WORD;
  assign unused_pc  = ^{pcF[31:DEPTH_LOG2+2], pcF[1:0]};

  assign core_rst_n = core_rst_q;
  assign load_done  = (state_q == StRun);
  assign load_err   = (state_q == StErr);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: stimulus pushes expectations,
// monitors pop them when the DUT finishes a load or a read is presented.
module tb_imem_boot_loader;

  localparam logic [31:0] Nop = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = 8'h00;
  logic        ld_ready;
  logic        core_rst_n;
  logic        load_done;
  logic        load_err;
  logic [31:0] pcF = 32'h0;
  logic [31:0] instrF;

  always #5 clk = ~clk;

  imem_boot_loader #(
    .DEPTH_LOG2(8),
    .NOP_WORD  (32'h00000013)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .core_rst_n(core_rst_n),
    .load_done (load_done),
    .load_err  (load_err),
    .pcF       (pcF),
    .instrF    (instrF)
  );

  typedef struct {int kind; string name; logic [31:0] exp;} rd_t;
  typedef struct {string name; bit done; bit err; int hs;} term_t;

  int          checks = 0;
  int          errors = 0;
  rd_t         rd_q[$];
  term_t       term_q[$];
  event        rd_ev;
  logic [31:0] ref_word [256];
  bit          ref_valid [256];
  int          hs_cnt = 0;
  bit          term_seen = 1'b0;
  int          term_age = 0;
  bit          term_done_exp = 1'b0;
  term_t       mt;
  rd_t         mr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Terminal-event monitor; handshakes are counted at the negedge before their edge.
  always @(negedge rst_n) begin
    hs_cnt    = 0;
    term_seen = 1'b0;
    term_age  = 0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (term_seen) begin
        term_age++;
        if (term_age == 1) chk("core_rst_n_after_term", {31'b0, core_rst_n}, {31'b0, term_done_exp});
      end else if (load_done || load_err) begin
        term_seen = 1'b1;
        term_age  = 0;
        chk("core_rst_n_at_term", {31'b0, core_rst_n}, 32'd0);
        if (term_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_term: got done=%0b err=%0b expected no completion",
                   load_done, load_err);
        end else begin
          mt = term_q.pop_front();
          term_done_exp = mt.done;
          chk({mt.name, "_done"}, {31'b0, load_done}, {31'b0, mt.done});
          chk({mt.name, "_err"}, {31'b0, load_err}, {31'b0, mt.err});
          chk({mt.name, "_handshakes"}, hs_cnt, mt.hs);
        end
      end
      if (ld_valid && ld_ready) hs_cnt++;
    end
  end

  always @(rd_ev) begin
    while (rd_q.size() > 0) begin
      mr = rd_q.pop_front();
      if (mr.kind == 0) chk(mr.name, instrF, mr.exp);
      else chk(mr.name, {28'b0, ld_ready, core_rst_n, load_done, load_err}, mr.exp);
    end
  end

  task automatic read_chk(input string name, input logic [31:0] pc);
    int idx;
    idx = int'((pc >> 2) & 32'hFF);
    pcF = pc;
    #1;
    rd_q.push_back('{0, name, ref_valid[idx] ? ref_word[idx] : Nop});
    ->rd_ev;
    #1;
  endtask

  // exp = {ld_ready, core_rst_n, load_done, load_err}
  task automatic status_chk(input string name, input logic [3:0] exp);
    #1;
    rd_q.push_back('{1, name, {28'b0, exp}});
    ->rd_ev;
    #1;
  endtask

  task automatic do_reset(input logic [31:0] pc);
    ld_valid = 1'b0;
    rst_n    = 1'b0;
    for (int i = 0; i < 256; i++) ref_valid[i] = 1'b0;
    status_chk("reset_status", 4'b1000);
    read_chk("reset_instr", pc);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // mode 0: no bubbles, 1: alternate cycles, 2: random bubbles
  task automatic send(input bit [7:0] b[$], input int mode);
    bit alt;
    alt = 1'b0;
    for (int i = 0; i < b.size(); i++) begin
      bit done;
      bit v;
      int guard;
      done  = 1'b0;
      guard = 0;
      while (!done) begin
        case (mode)
          0:       v = 1'b1;
          1:       begin v = alt; alt = ~alt; end
          default: v = ($urandom_range(0, 2) != 0);
        endcase
        ld_valid = v;
        ld_data  = v ? b[i] : 8'($urandom);
        done     = v && ld_ready;
        @(posedge clk);
        #1;
        guard++;
        if (!done && guard > 40) begin
          checks++;
          errors++;
          $display("FAIL send_timeout: byte %0d not accepted after %0d cycles, expected accept",
                   i, guard);
          ld_valid = 1'b0;
          return;
        end
      end
    end
    ld_valid = 1'b0;
  endtask

  // Reference: 16-bit LE length, then len little-endian words.
  task automatic model_load(input bit [7:0] b[$], input string name);
    int len;
    len = int'(b[0]) + 256 * int'(b[1]);
    if (len == 0) term_q.push_back('{name, 1'b1, 1'b0, 2});
    else if (len > 256) term_q.push_back('{name, 1'b0, 1'b1, 2});
    else begin
      term_q.push_back('{name, 1'b1, 1'b0, 2 + 4 * len});
      for (int i = 0; i < len; i++) begin
        ref_word[i]  = {b[2+4*i+3], b[2+4*i+2], b[2+4*i+1], b[2+4*i]};
        ref_valid[i] = 1'b1;
      end
    end
  endtask

  task automatic run_load(input bit [7:0] b[$], input int mode, input string name);
    model_load(b, name);
    send(b, mode);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    bit [7:0] two[$];
    bit [7:0] q[$];
    int len;

    two = '{8'h02, 8'h00, 8'h33, 8'h05, 8'hB5, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    repeat (2) @(posedge clk);
    #1;
    do_reset(32'h0);

    run_load(two, 0, "two_word");
    read_chk("two_pc0", 32'h0);
    read_chk("two_pc4", 32'h4);
    read_chk("two_pc8", 32'h8);
    status_chk("two_status", 4'b0110);

    do_reset(32'h4);
    run_load(two, 1, "two_alt");
    read_chk("alt_pc0", 32'h0);
    read_chk("alt_pc4", 32'h4);
    do_reset(32'h0);
    run_load(two, 2, "two_rand");
    read_chk("rand_pc0", 32'h0);
    read_chk("rand_pc4", 32'h4);
    read_chk("rand_pc8", 32'h8);

    do_reset(32'h0);
    q = '{8'h00, 8'h00};
    run_load(q, 2, "zero_len");
    status_chk("zero_status", 4'b0110);
    for (int i = 0; i < 256; i++) read_chk("zero_nop", (i << 2) | 32'($urandom_range(0, 3)));

    do_reset(32'h4);
    q = '{8'h01, 8'h01};
    run_load(q, 0, "oversize");
    repeat (50) @(posedge clk);
    #1;
    status_chk("oversize_50", 4'b0001);
    for (int i = 0; i < 10; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'($urandom);
      @(posedge clk);
      #1;
    end
    ld_valid = 1'b0;
    status_chk("oversize_junk", 4'b0001);
    read_chk("oversize_nop", 32'h0);

    do_reset(32'h0);
    q = '{8'h00, 8'h01};
    for (int i = 0; i < 256; i++) begin
      q.push_back(8'(i));
      q.push_back(8'h00);
      q.push_back(8'h00);
      q.push_back(8'h00);
    end
    run_load(q, 2, "full_depth");
    read_chk("full_3fc", 32'h3FC);
    read_chk("full_alias_400", 32'h400);
    read_chk("full_3ff", 32'h3FF);
    read_chk("full_mid", 32'h200);
    ld_valid = 1'b1;
    ld_data  = 8'hAA;
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    read_chk("full_after_junk", 32'h0);

    // Reset mid-load: word 0 complete, word 1 partial.
    do_reset(32'h0);
    q = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send(q, 2);
    ref_word[0]  = 32'h44332211;
    ref_valid[0] = 1'b1;
    read_chk("midload_word0", 32'h0);
    status_chk("midload_status", 4'b1000);
    do_reset(32'h0);
    q = '{8'h02, 8'h00};
    for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
    run_load(q, 2, "after_reset");
    read_chk("after_reset_pc0", 32'h0);
    read_chk("after_reset_pc4", 32'h4);

    for (int t = 0; t < 6; t++) begin
      do_reset($urandom);
      len = (t == 5) ? $urandom_range(257, 65535) : $urandom_range(1, 40);
      q = '{8'(len), 8'(len >> 8)};
      if (len <= 256) for (int i = 0; i < 4 * len; i++) q.push_back(8'($urandom));
      run_load(q, 2, "random_load");
      read_chk("rnd_first", 32'h0);
      read_chk("rnd_last", 32'((len - 1) << 2) | 32'($urandom_range(0, 3)));
      read_chk("rnd_past", 32'(len << 2));
      read_chk("rnd_alias", {22'($urandom), 10'($urandom_range(0, 1023))});
    end

    repeat (3) @(posedge clk);
    checks++;
    if (term_q.size() != 0) begin
      errors++;
      $display("FAIL pending_completions: got %0d outstanding expected 0", term_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
